ifetch_queue: RTL and testbench

Instruction fetch unit with prefetch queue for the 5-stage MIPS pipeline. It generates sequential fetch addresses and runs a req/ack handshake with a variable-latency instruction memory. Fetched words are buffered in a small FIFO, and the head is presented to the ID stage under a valid/ready handshake. A branch redirect from ID flushes the queue and restarts fetch at the target, including correct discard of a request already in flight.

---
 rtl/ifetch_queue_if.sv | 24 ++
 rtl/ifetch_queue.sv | 125 ++++++++++++
 tb/tb_ifetch_queue.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel, branch redirect
// from ID, and the valid/ready instruction handoff to ID.
interface ifetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_ir;
    logic [31:0] id_npc;
    logic        id_ready;

    modport master (
        output mem_req, mem_addr, id_valid, id_ir, id_npc,
        input  mem_ack, mem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  mem_req, mem_addr, id_valid, id_ir, id_npc,
        output mem_ack, mem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry prefetch queue, one request
// in flight at a time, and redirect flush with discard of an in-flight word.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          CLK,
    input  logic          RST_X,
    ifetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   req_addr_reg, req_addr_next;
    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   ir_vec  [DEPTH];
    logic [31:0]   npc_vec [DEPTH];
    logic          push, pop, has_space;

    assign bus.id_valid = (count_reg != '0);
    assign pop          = bus.id_valid & bus.id_ready & ~bus.redirect;
    assign push         = (state_reg == FETCH) & bus.mem_ack & ~bus.redirect;
    assign has_space    = (count_next < CW'(DEPTH));

    assign bus.mem_req  = (state_reg != IDLE);
    assign bus.mem_addr = req_addr_reg;
    assign bus.id_ir    = bus.id_valid ? ir_vec[head_reg]  : 32'h0;
    assign bus.id_npc   = bus.id_valid ? npc_vec[head_reg] : 32'h0;

    // Queue storage: one register pair per entry, written at the tail.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [31:0] ir_reg, npc_reg;
        always_ff @(posedge CLK) begin
            if (push && (tail_reg == PW'(gi))) begin
                ir_reg  <= bus.mem_rdata;
                npc_reg <= req_addr_reg + 32'd4;
            end
        end
        assign ir_vec[gi]  = ir_reg;
        assign npc_vec[gi] = npc_reg;
    end

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (bus.redirect) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) tail_next = tail_reg + PW'(1);
            if (pop)  head_next = head_reg + PW'(1);
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_addr_next = req_addr_reg;
        case (state_reg)
            IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_next = bus.redirect_pc;
                    req_addr_next = bus.redirect_pc;
                    state_next    = FETCH;
                end else if (has_space) begin
                    req_addr_next = fetch_pc_reg;
                    state_next    = FETCH;
                end
            end
            FETCH: begin
                if (bus.redirect && bus.mem_ack) begin
                    fetch_pc_next = bus.redirect_pc;
                    req_addr_next = bus.redirect_pc;
                end else if (bus.redirect) begin
                    // Request still outstanding: wait out its ack before retargeting.
                    fetch_pc_next = bus.redirect_pc;
                    state_next    = DRAIN;
                end else if (bus.mem_ack) begin
                    if (has_space) begin
                        req_addr_next = req_addr_reg + 32'd4;
                        fetch_pc_next = req_addr_reg + 32'd8;
                    end else begin
                        fetch_pc_next = req_addr_reg + 32'd4;
                        state_next    = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (bus.redirect) fetch_pc_next = bus.redirect_pc;
                if (bus.mem_ack) begin
                    req_addr_next = bus.redirect ? bus.redirect_pc : fetch_pc_reg;
                    state_next    = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            req_addr_reg <= RESET_PC;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_addr_reg <= req_addr_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory model returns mem[addr>>2]=addr with
// programmable latency; a monitor checks every ID handoff against a scoreboard.
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic CLK   = 1'b0;
    logic RST_X = 1'b0;

    ifetch_queue_if bus();

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 0;
    int          wc       = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Memory: ack after 'lat' wait cycles, same-cycle data.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge CLK);
            if (bus.mem_ack) wc = 0;
            if (!RST_X || !bus.mem_req) begin
                bus.mem_ack = 1'b0;
                wc = 0;
            end else if (wc >= lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = bus.mem_addr;
            end else begin
                bus.mem_ack = 1'b0;
                wc++;
            end
        end
    end

    // Monitor: every accepted head is compared with the next expected entry.
    initial begin
        forever begin
            @(negedge CLK);
            #3;
            if (RST_X && bus.id_valid && bus.id_ready && !bus.redirect) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got ir=%h npc=%h, required no entry", bus.id_ir, bus.id_npc);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("pop ir=%h npc=%h (required ir=%h npc=%h)", bus.id_ir, bus.id_npc, mon_e[63:32], mon_e[31:0]);
                    chk("id_ir", bus.id_ir, mon_e[63:32]);
                    chk("id_npc", bus.id_npc, mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] a);
        exp_q.push_back({a, a + 32'd4});
    endtask

    task automatic do_reset();
        RST_X           = 1'b0;
        bus.redirect    = 1'b0;
        bus.id_ready    = 1'b0;
        lat             = 0;
        #1;
        chk("rst_mem_req",  32'(bus.mem_req),  32'h0);
        chk("rst_mem_addr", bus.mem_addr,      RESET_PC);
        chk("rst_id_valid", 32'(bus.id_valid), 32'h0);
        chk("rst_id_ir",    bus.id_ir,         32'h0);
        chk("rst_id_npc",   bus.id_npc,        32'h0);
        exp_q.delete();
        step();
        step();
        RST_X = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'h0);
        bus.id_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.id_ready    = 1'b0;
        step();
        step();

        // Zero-wait memory, ID always ready: one instruction per cycle.
        do_reset();
        bus.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_entry(32'(4 * i));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_mem_addr", bus.mem_addr, 32'(4 * i));
            chk("t1_mem_req", 32'(bus.mem_req), 32'h1);
            if (i < 2) chk("t1_id_valid", 32'(bus.id_valid), 32'(i));
        end
        drain("t1_drain");

        // Back-pressure: queue fills to DEPTH, fetch stops, resumes at 16.
        do_reset();
        for (int s = 1; s <= 10; s++) begin
            step();
            if (s <= 4) begin
                chk("t2_mem_req", 32'(bus.mem_req), 32'h1);
                chk("t2_mem_addr", bus.mem_addr, 32'(4 * (s - 1)));
            end else begin
                chk("t2_mem_req_idle", 32'(bus.mem_req), 32'h0);
                chk("t2_head_stable", bus.id_ir, 32'h0);
            end
        end
        for (int i = 0; i < 5; i++) expect_entry(32'(4 * i));
        bus.id_ready = 1'b1;
        step();
        chk("t2_resume_req", 32'(bus.mem_req), 32'h1);
        chk("t2_resume_addr", bus.mem_addr, 32'h10);
        drain("t2_drain");

        // Three wait cycles per access: held address, one word per 4 cycles.
        do_reset();
        lat = 3;
        bus.id_ready = 1'b1;
        for (int i = 0; i < 3; i++) expect_entry(32'(4 * i));
        for (int s = 1; s <= 12; s++) begin
            step();
            chk("t3_mem_addr", bus.mem_addr, 32'(4 * ((s - 1) / 4)));
            chk("t3_id_valid", 32'(bus.id_valid), 32'((s >= 5) && (s % 4 == 1)));
        end
        drain("t3_drain");

        // Redirect while the request to 8 waits: drain, discard, refetch 0x100.
        do_reset();
        step();
        chk("t4_addr0", bus.mem_addr, 32'h0);
        step();
        chk("t4_addr4", bus.mem_addr, 32'h4);
        lat = 100;
        step();
        chk("t4_addr8", bus.mem_addr, 32'h8);
        chk("t4_no_ack", 32'(bus.mem_ack), 32'h0);
        chk("t4_two_valid", 32'(bus.id_valid), 32'h1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect = 1'b0;
        chk("t4_flushed", 32'(bus.id_valid), 32'h0);
        chk("t4_drain_req", 32'(bus.mem_req), 32'h1);
        chk("t4_drain_addr", bus.mem_addr, 32'h8);
        step();
        chk("t4_drain_hold", bus.mem_addr, 32'h8);
        lat = 0;
        step();
        chk("t4_late_ack", 32'(bus.mem_ack), 32'h1);
        chk("t4_drop_valid", 32'(bus.id_valid), 32'h0);
        step();
        chk("t4_target_addr", bus.mem_addr, 32'h100);
        chk("t4_discarded", 32'(bus.id_valid), 32'h0);
        expect_entry(32'h100);
        bus.id_ready = 1'b1;
        drain("t4_drain");

        // Redirect coinciding with ack and pop, two entries queued.
        do_reset();
        step();
        step();
        step();
        chk("t5_valid", 32'(bus.id_valid), 32'h1);
        chk("t5_ack", 32'(bus.mem_ack), 32'h1);
        chk("t5_addr8", bus.mem_addr, 32'h8);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        bus.id_ready    = 1'b1;
        step();
        bus.redirect = 1'b0;
        chk("t5_flushed", 32'(bus.id_valid), 32'h0);
        chk("t5_target_addr", bus.mem_addr, 32'h200);
        expect_entry(32'h200);
        drain("t5_drain");

        // Asynchronous reset while draining, then restart from RESET_PC.
        do_reset();
        step();
        step();
        lat = 100;
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h300;
        step();
        bus.redirect = 1'b0;
        chk("t6_in_drain", bus.mem_addr, 32'h8);
        do_reset();
        bus.id_ready = 1'b1;
        expect_entry(RESET_PC);
        step();
        chk("t6_restart_req", 32'(bus.mem_req), 32'h1);
        chk("t6_restart_addr", bus.mem_addr, RESET_PC);
        drain("t6_drain");

        // Address wrap from 32'hFFFFFFFC to 0.
        do_reset();
        bus.id_ready = 1'b1;
        step();
        chk("t7_addr0", bus.mem_addr, 32'h0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        expect_entry(32'hFFFF_FFF8);
        expect_entry(32'hFFFF_FFFC);
        expect_entry(32'h0);
        step();
        bus.redirect = 1'b0;
        chk("t7_addr_f8", bus.mem_addr, 32'hFFFF_FFF8);
        step();
        chk("t7_addr_fc", bus.mem_addr, 32'hFFFF_FFFC);
        step();
        chk("t7_addr_wrap", bus.mem_addr, 32'h0);
        drain("t7_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
